// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the decimal receiver and sender_uart:
// ASCII digit bounds, oversampling ratio and the byte FSM state encoding.
package uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam int         OVERSAMPLE = 16;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_e;

  function automatic logic isDigit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, 16x oversample tick generator and
// byte FSM. The valid/error strobes fire on the stop-bit sample tick itself.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk_i,
  input  logic       rstN_i,
  input  logic       rx_i,
  output logic [7:0] rxByte_o,
  output logic       byteValid_o,
  output logic       frameErr_o
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic              rxMeta_q, rxSync_q;
  logic [TICK_W-1:0] tickDiv_q;
  logic              tick;
  rxState_e          state_q;
  logic [3:0]        sampleCnt_q;
  logic [2:0]        bitIdx_q;
  logic [7:0]        shift_q;
  logic              stopSample;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
    end
  end

  assign tick = (tickDiv_q == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) tickDiv_q <= '0;
    else         tickDiv_q <= tick ? '0 : tickDiv_q + TICK_W'(1);
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_q     <= START;
            sampleCnt_q <= '0;
          end
        end
        // A start bit that is high again at mid-bit was a glitch: drop it silently.
        START: begin
          if (tick) begin
            if (sampleCnt_q == 4'd7) begin
              sampleCnt_q <= '0;
              bitIdx_q    <= '0;
              state_q     <= rxSync_q ? IDLE : DATA;
            end else begin
              sampleCnt_q <= sampleCnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sampleCnt_q == 4'd15) begin
              sampleCnt_q <= '0;
              shift_q     <= {rxSync_q, shift_q[7:1]};
              if (bitIdx_q == 3'd7) state_q <= STOP;
              else                  bitIdx_q <= bitIdx_q + 3'd1;
            end else begin
              sampleCnt_q <= sampleCnt_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sampleCnt_q == 4'd15) begin
              sampleCnt_q <= '0;
              state_q     <= IDLE;
            end else begin
              sampleCnt_q <= sampleCnt_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stopSample  = tick && (state_q == STOP) && (sampleCnt_q == 4'd15);
  assign byteValid_o = stopSample & rxSync_q;
  assign frameErr_o  = stopSample & ~rxSync_q;
  assign rxByte_o    = shift_q;

endmodule

// File: rtl/receiver_uart_dec.sv
// Decimal-ASCII UART receiver: assembles DIGITS ASCII digits (MSB first)
// into a binary value. All outputs are registered one clock after the stop sample.
module receiver_uart_dec
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DIGITS   = 3,
  parameter int DATA_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] o_recv_data,
  output logic              rx_done,
  output logic [7:0]        o_rx_byte,
  output logic              o_byte_valid,
  output logic              o_err
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  logic [7:0]        byteRaw;
  logic              byteStrobe, frameErr;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  count_q;

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) rxByteInst (
    .clk_i      (clk),
    .rstN_i     (rst),
    .rx_i       (rx),
    .rxByte_o   (byteRaw),
    .byteValid_o(byteStrobe),
    .frameErr_o (frameErr)
  );

  always_comb begin
    acc_d = acc_q * DATA_W'(10) + DATA_W'(byteRaw - ASCII_ZERO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      count_q      <= '0;
      o_recv_data  <= '0;
      rx_done      <= 1'b0;
      o_rx_byte    <= '0;
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
      if (byteStrobe) begin
        o_rx_byte    <= byteRaw;
        o_byte_valid <= 1'b1;
        if (!isDigit(byteRaw)) begin
          o_err   <= 1'b1;
          acc_q   <= '0;
          count_q <= '0;
        end else if (count_q == CNT_W'(DIGITS - 1)) begin
          o_recv_data <= acc_d;
          rx_done     <= 1'b1;
          acc_q       <= '0;
          count_q     <= '0;
        end else begin
          acc_q   <= acc_d;
          count_q <= count_q + CNT_W'(1);
        end
      end else if (frameErr) begin
        // A broken frame discards any partially assembled number.
        o_err   <= 1'b1;
        acc_q   <= '0;
        count_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_receiver_uart_dec.sv
// Directed bench for receiver_uart_dec at a scaled bit rate (4 clocks/tick,
// 64 clocks/bit): table of bytes with expected pulses, plus glitch and reset sequences.
module tb_receiver_uart_dec;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [9:0] o_recv_data;
  logic       rx_done;
  logic [7:0] o_rx_byte;
  logic       o_byte_valid;
  logic       o_err;

  int checks   = 0;
  int failures = 0;

  int         validCnt = 0, errCnt = 0, doneCnt = 0;
  int         overlapCnt = 0, doneNoValid = 0;
  logic [7:0] lastByte = '0;
  logic [9:0] lastDoneData = '0;

  typedef struct {
    logic [7:0] b;
    bit         stopOk;
    int         gap;
    bit         expValid;
    bit         expErr;
    bit         expDone;
    int         expData;
  } vec_t;

  vec_t vecs[20];

  receiver_uart_dec #(
    .CLK_FREQ(1_600_000),
    .BAUD    (25_000),
    .DIGITS  (3),
    .DATA_W  (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .o_recv_data (o_recv_data),
    .rx_done     (rx_done),
    .o_rx_byte   (o_rx_byte),
    .o_byte_valid(o_byte_valid),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (o_byte_valid) begin
      validCnt++;
      lastByte = o_rx_byte;
    end
    if (o_err) errCnt++;
    if (rx_done) begin
      doneCnt++;
      lastDoneData = o_recv_data;
      if (!o_byte_valid) doneNoValid++;
    end
    if (rx_done && o_err) overlapCnt++;
  end

  task automatic waitClks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit stopOk);
    rx = 1'b0;
    waitClks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitClks(BIT_CLKS);
    end
    if (stopOk) begin
      rx = 1'b1;
      waitClks(BIT_CLKS);
    end else begin
      rx = 1'b0;
      waitClks(40);
      rx = 1'b1;
      waitClks(BIT_CLKS - 40);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sendByte(v.b, v.stopOk);
    rx = 1'b1;
    if (v.gap > 0) waitClks(v.gap);
  endtask

  task automatic sendFrame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    sendByte(d0, 1'b1);
    sendByte(d1, 1'b1);
    sendByte(d2, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " o_recv_data"},  32'(o_recv_data),  32'd0);
    checkOutput({tag, " rx_done"},      32'(rx_done),      32'd0);
    checkOutput({tag, " o_rx_byte"},    32'(o_rx_byte),    32'd0);
    checkOutput({tag, " o_byte_valid"}, 32'(o_byte_valid), 32'd0);
    checkOutput({tag, " o_err"},        32'(o_err),        32'd0);
  endtask

  initial begin
    int v0, e0, d0;

    //          byte   stop  gap  valid err done data
    vecs[0]  = '{8'h34, 1'b1, 0,   1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{8'h30, 1'b1, 0,   1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{8'h30, 1'b1, 0,   1'b1, 1'b0, 1'b1, 400};
    vecs[3]  = '{8'h39, 1'b1, 0,   1'b1, 1'b0, 1'b0, 400};
    vecs[4]  = '{8'h39, 1'b1, 0,   1'b1, 1'b0, 1'b0, 400};
    vecs[5]  = '{8'h39, 1'b1, 0,   1'b1, 1'b0, 1'b1, 999};
    vecs[6]  = '{8'h30, 1'b1, 0,   1'b1, 1'b0, 1'b0, 999};
    vecs[7]  = '{8'h30, 1'b1, 0,   1'b1, 1'b0, 1'b0, 999};
    vecs[8]  = '{8'h37, 1'b1, 0,   1'b1, 1'b0, 1'b1, 7};
    vecs[9]  = '{8'h34, 1'b1, 0,   1'b1, 1'b0, 1'b0, 7};
    vecs[10] = '{8'h41, 1'b1, 0,   1'b1, 1'b1, 1'b0, 7};
    vecs[11] = '{8'h31, 1'b1, 0,   1'b1, 1'b0, 1'b0, 7};
    vecs[12] = '{8'h32, 1'b1, 0,   1'b1, 1'b0, 1'b0, 7};
    vecs[13] = '{8'h33, 1'b1, 0,   1'b1, 1'b0, 1'b1, 123};
    vecs[14] = '{8'h33, 1'b1, 0,   1'b1, 1'b0, 1'b0, 123};
    vecs[15] = '{8'h35, 1'b0, 128, 1'b0, 1'b1, 1'b0, 123};
    vecs[16] = '{8'h33, 1'b1, 0,   1'b1, 1'b0, 1'b0, 123};
    vecs[17] = '{8'h32, 1'b1, 0,   1'b1, 1'b0, 1'b0, 123};
    vecs[18] = '{8'h31, 1'b1, 0,   1'b1, 1'b0, 1'b1, 321};
    vecs[19] = '{8'h0D, 1'b1, 64,  1'b1, 1'b1, 1'b0, 321};

    rst = 1'b0;
    rx  = 1'b1;
    waitClks(5);
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    waitClks(20);

    for (int i = 0; i < 20; i++) begin
      v0 = validCnt; e0 = errCnt; d0 = doneCnt;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d byte_valid pulses", i), 32'(validCnt - v0), 32'(vecs[i].expValid));
      if (vecs[i].expValid)
        checkOutput($sformatf("vec%0d o_rx_byte", i), 32'(lastByte), 32'(vecs[i].b));
      checkOutput($sformatf("vec%0d err pulses", i), 32'(errCnt - e0), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d done pulses", i), 32'(doneCnt - d0), 32'(vecs[i].expDone));
      if (vecs[i].expDone)
        checkOutput($sformatf("vec%0d data at done", i), 32'(lastDoneData), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d o_recv_data held", i), 32'(o_recv_data), 32'(vecs[i].expData));
    end

    // Short low glitch on an idle line must be ignored, then a normal frame still decodes.
    waitClks(128);
    v0 = validCnt; e0 = errCnt; d0 = doneCnt;
    rx = 1'b0;
    waitClks(8);
    rx = 1'b1;
    waitClks(100);
    checkOutput("glitch byte_valid pulses", 32'(validCnt - v0), 32'd0);
    checkOutput("glitch err pulses",        32'(errCnt - e0),   32'd0);
    checkOutput("glitch done pulses",       32'(doneCnt - d0),  32'd0);
    sendFrame(8'h35, 8'h35, 8'h35);
    @(negedge clk);
    checkOutput("after glitch done pulses", 32'(doneCnt - d0),  32'd1);
    checkOutput("after glitch data",        32'(lastDoneData),  32'd555);

    // Reset in the middle of the third digit of "456" aborts the frame.
    waitClks(64);
    d0 = doneCnt;
    sendByte(8'h34, 1'b1);
    sendByte(8'h35, 1'b1);
    rx = 1'b0;
    waitClks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h36 >> i) & 1'b1;
      waitClks(BIT_CLKS);
    end
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    checkAllZero("mid-frame reset");
    waitClks(20);
    @(negedge clk);
    rst = 1'b1;
    waitClks(128);
    checkOutput("reset aborted 456 done pulses", 32'(doneCnt - d0), 32'd0);
    sendFrame(8'h37, 8'h38, 8'h39);
    @(negedge clk);
    checkOutput("post-reset done pulses", 32'(doneCnt - d0), 32'd1);
    checkOutput("post-reset data",        32'(lastDoneData), 32'd789);
    checkOutput("post-reset o_recv_data", 32'(o_recv_data),  32'd789);

    checkOutput("rx_done with o_err same cycle",  32'(overlapCnt),  32'd0);
    checkOutput("rx_done without o_byte_valid",   32'(doneNoValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
